// File: rtl/int_factor_ctrl.sv
// Interrupt factor/mask register file with prioritised request FSM (IDLE/REQ/WAIT).
// Optional serial interrupt source is enabled by defining SERIAL_INT_EN.
module int_factor_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  clock_set,
    input  logic [1:0]  stopwatch_set,
    input  logic        prog_set,
    input  logic        serial_set,
    input  logic        k0_set,
    input  logic        k1_set,
    input  logic [11:0] bus_addr,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [3:0]  bus_wdata,
    output logic [3:0]  bus_rdata,
    output logic        bus_hit,
    input  logic        ie,
    output logic        int_req,
    output logic [3:0]  int_vector,
    input  logic        int_ack
);
    localparam int unsigned NREG = 6;
    localparam int unsigned DW   = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    // Implemented bits per register index: clock, stopwatch, prog, serial, K0, K1
    function automatic logic [DW-1:0] reg_mask(input int unsigned i);
        case (i)
            0:       reg_mask = 4'hF;
            1:       reg_mask = 4'h3;
`ifdef SERIAL_INT_EN
            3:       reg_mask = 4'h1;
`else
            3:       reg_mask = 4'h0;
`endif
            default: reg_mask = 4'h1;
        endcase
    endfunction

    logic [NREG-1:0][DW-1:0] fac_q, fac_d, msk_q, msk_d, set_vec;
    logic [NREG-1:0]         pend;
    state_t                  state_q, state_d;
    logic                    int_req_q, int_req_d;
    logic [DW-1:0]           int_vector_q, int_vector_d;
    logic [DW-1:0]           prio_vec, fac_word, msk_word;
    logic [2:0]              sel_idx;
    logic                    idx_ok, fac_sel, msk_sel;

    // Address decode
    always_comb begin
        sel_idx = bus_addr[2:0];
        idx_ok  = !bus_addr[3] && (sel_idx <= 3'd5);
`ifndef SERIAL_INT_EN
        if (sel_idx == 3'd3) idx_ok = 1'b0;
`endif
        fac_sel = idx_ok && (bus_addr[11:4] == 8'hF0);
        msk_sel = idx_ok && (bus_addr[11:4] == 8'hF1);
        bus_hit = fac_sel || msk_sel;
    end

    // Register file next state and read mux; a set pulse overrides a read-clear
    always_comb begin
        set_vec    = '0;
        set_vec[0] = clock_set;
        set_vec[1] = {2'b00, stopwatch_set};
        set_vec[2] = {3'b000, prog_set};
        set_vec[3] = {3'b000, serial_set};
        set_vec[4] = {3'b000, k0_set};
        set_vec[5] = {3'b000, k1_set};
        fac_d      = fac_q;
        msk_d      = msk_q;
        fac_word   = '0;
        msk_word   = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (3'(i) == sel_idx) begin
                fac_word = fac_q[i];
                msk_word = msk_q[i];
                if (fac_sel && bus_rd) fac_d[i] = '0;
                if (msk_sel && bus_wr) msk_d[i] = bus_wdata & reg_mask(i);
            end
            fac_d[i] = (fac_d[i] | set_vec[i]) & reg_mask(i);
            pend[i]  = |(fac_q[i] & msk_q[i]);
        end
        bus_rdata = fac_sel ? fac_word : (msk_sel ? msk_word : '0);
    end

    // Fixed priority encoder
    always_comb begin
        if      (pend[2]) prio_vec = 4'hC;
        else if (pend[3]) prio_vec = 4'hA;
        else if (pend[5]) prio_vec = 4'h8;
        else if (pend[4]) prio_vec = 4'h6;
        else if (pend[1]) prio_vec = 4'h4;
        else if (pend[0]) prio_vec = 4'h2;
        else              prio_vec = 4'h0;
    end

    // Request state machine
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_vector_d = int_vector_q;
        case (state_q)
            ST_IDLE: begin
                int_req_d = 1'b0;
                if (ie && (|pend)) begin
                    state_d      = ST_REQ;
                    int_req_d    = 1'b1;
                    int_vector_d = prio_vec;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d   = ST_WAIT;
                    int_req_d = 1'b0;
                end else if (!ie || !(|pend)) begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end else begin
                    int_vector_d = prio_vec;
                end
            end
            ST_WAIT: begin
                int_req_d = 1'b0;
                if (!ie) state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fac_q        <= '0;
            msk_q        <= '0;
            state_q      <= ST_IDLE;
            int_req_q    <= 1'b0;
            int_vector_q <= '0;
        end else begin
            fac_q        <= fac_d;
            msk_q        <= msk_d;
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_vector = int_vector_q;
endmodule

// File: tb/tb_int_factor_ctrl.sv
// Directed bench for int_factor_ctrl; expected values are hand-derived constants.
module tb_int_factor_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  clock_set = '0;
    logic [1:0]  stopwatch_set = '0;
    logic        prog_set = 1'b0, serial_set = 1'b0, k0_set = 1'b0, k1_set = 1'b0;
    logic [11:0] bus_addr = '0;
    logic        bus_wr = 1'b0, bus_rd = 1'b0;
    logic [3:0]  bus_wdata = '0;
    logic [3:0]  bus_rdata;
    logic        bus_hit;
    logic        ie = 1'b0;
    logic        int_req;
    logic [3:0]  int_vector;
    logic        int_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    int_factor_ctrl dut (
        .clk(clk), .reset(reset), .clock_set(clock_set), .stopwatch_set(stopwatch_set),
        .prog_set(prog_set), .serial_set(serial_set), .k0_set(k0_set), .k1_set(k1_set),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_hit(bus_hit), .ie(ie), .int_req(int_req),
        .int_vector(int_vector), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] d);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        cyc();
        bus_wr = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [3:0] exp, input string tag);
        bus_addr = a; bus_rd = 1'b1;
        #1 chk(tag, bus_rdata, exp);
        cyc();
        bus_rd = 1'b0;
    endtask

    task automatic hit(input logic [11:0] a, input logic exp);
        bus_addr = a;
        #1 chk($sformatf("hit_%h", a), {3'b000, bus_hit}, {3'b000, exp});
    endtask

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_req", {3'b0, int_req}, 4'h0);
        chk("rst_vec", int_vector, 4'h0);
        rd(12'hF00, 4'h0, "rst_fac_clk");
        rd(12'hF10, 4'h0, "rst_msk_clk");
        hit(12'hF00, 1'b1); hit(12'hF05, 1'b1); hit(12'hF06, 1'b0);
        hit(12'hF10, 1'b1); hit(12'hF15, 1'b1); hit(12'hF16, 1'b0);
        hit(12'hF08, 1'b0); hit(12'h000, 1'b0); hit(12'hE00, 1'b0);
`ifdef SERIAL_INT_EN
        hit(12'hF03, 1'b1); hit(12'hF13, 1'b1);
`else
        hit(12'hF03, 1'b0); hit(12'hF13, 1'b0);
`endif

        // Basic clock request, two edges after the pulse
        wr(12'hF10, 4'h1);
        ie = 1'b1;
        clock_set = 4'h1; cyc(); clock_set = 4'h0;
        chk("t1_req_edge1", {3'b0, int_req}, 4'h0);
        cyc();
        chk("t1_req_edge2", {3'b0, int_req}, 4'h1);
        chk("t1_vec", int_vector, 4'h2);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        chk("t1_ack_drop", {3'b0, int_req}, 4'h0);
        cyc();
        chk("t1_wait_hold", {3'b0, int_req}, 4'h0);
        ie = 1'b0; cyc();
        rd(12'hF00, 4'h1, "t1_fac");

        // Masked-out bit does not request; masked-in bit does
        wr(12'hF10, 4'h4);
        ie = 1'b1;
        clock_set = 4'h1; cyc(); clock_set = 4'h0;
        cyc(); cyc();
        chk("t2_masked", {3'b0, int_req}, 4'h0);
        clock_set = 4'h4; cyc(); clock_set = 4'h0;
        cyc();
        chk("t2_req", {3'b0, int_req}, 4'h1);
        chk("t2_vec", int_vector, 4'h2);
        ie = 1'b0; cyc();
        chk("t2_ie_fall", {3'b0, int_req}, 4'h0);
        rd(12'hF00, 4'h5, "t2_fac");

        // Read-clear drops the request via REQ->IDLE
        wr(12'hF10, 4'hF);
        clock_set = 4'h3; cyc(); clock_set = 4'h0;
        ie = 1'b1; cyc();
        chk("t3_req", {3'b0, int_req}, 4'h1);
        rd(12'hF00, 4'h3, "t3_rdata");
        chk("t3_req_hold", {3'b0, int_req}, 4'h1);
        cyc();
        chk("t3_req_fall", {3'b0, int_req}, 4'h0);
        ie = 1'b0;
        rd(12'hF00, 4'h0, "t3_cleared");

        // Set beats read-clear in the same cycle
        clock_set = 4'h2; cyc(); clock_set = 4'h0;
        bus_addr = 12'hF00; bus_rd = 1'b1; clock_set = 4'h8;
        #1 chk("t4_rdata_old", bus_rdata, 4'h2);
        cyc();
        bus_rd = 1'b0; clock_set = 4'h0;
        rd(12'hF00, 4'h8, "t4_set_wins");

        // Priority prog over clock, ack, re-request after prog cleared
        wr(12'hF12, 4'h1);
        prog_set = 1'b1; clock_set = 4'h1; cyc(); prog_set = 1'b0; clock_set = 4'h0;
        ie = 1'b1; cyc();
        chk("t5_req", {3'b0, int_req}, 4'h1);
        chk("t5_vec_prog", int_vector, 4'hC);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        chk("t5_ack", {3'b0, int_req}, 4'h0);
        rd(12'hF02, 4'h1, "t5_prog_fac");
        chk("t5_wait", {3'b0, int_req}, 4'h0);
        ie = 1'b0; cyc();
        ie = 1'b1; cyc();
        chk("t5_rereq", {3'b0, int_req}, 4'h1);
        chk("t5_vec_clk", int_vector, 4'h2);
        ie = 1'b0; cyc();
        rd(12'hF00, 4'h1, "t5_clk_fac");

        // K1 > K0 > stopwatch, vector re-registers while in REQ
        wr(12'hF14, 4'h1); wr(12'hF15, 4'h1); wr(12'hF11, 4'hF);
        k0_set = 1'b1; stopwatch_set = 2'b10; cyc(); k0_set = 1'b0; stopwatch_set = 2'b00;
        ie = 1'b1; cyc();
        chk("t6_vec_k0", int_vector, 4'h6);
        k1_set = 1'b1; cyc(); k1_set = 1'b0;
        chk("t6_vec_k0_hold", int_vector, 4'h6);
        cyc();
        chk("t6_vec_k1", int_vector, 4'h8);
        rd(12'hF05, 4'h1, "t6_k1_fac");
        cyc();
        chk("t6_vec_back_k0", int_vector, 4'h6);
        ie = 1'b0; cyc();
        rd(12'hF04, 4'h1, "t6_k0_fac");
        cyc();
        ie = 1'b1; cyc();
        chk("t6_vec_sw", int_vector, 4'h4);
        ie = 1'b0; cyc();
        rd(12'hF01, 4'h2, "t6_sw_fac");

        // Factor writes ignored, mask readback without side effects
        wr(12'hF04, 4'h1);
        rd(12'hF04, 4'h0, "t7_fac_wr_ign");
        rd(12'hF11, 4'h3, "t7_msk_sw");
        rd(12'hF11, 4'h3, "t7_msk_sw_again");
        rd(12'hF10, 4'hF, "t7_msk_clk");
        rd(12'hF12, 4'h1, "t7_msk_prog");

        // Serial source
        wr(12'hF13, 4'h1);
        serial_set = 1'b1; cyc(); serial_set = 1'b0;
        ie = 1'b1; cyc();
`ifdef SERIAL_INT_EN
        chk("t8_ser_req", {3'b0, int_req}, 4'h1);
        chk("t8_ser_vec", int_vector, 4'hA);
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        ie = 1'b0; cyc();
        rd(12'hF13, 4'h1, "t8_ser_msk");
        rd(12'hF03, 4'h1, "t8_ser_fac");
`else
        chk("t8_ser_noreq", {3'b0, int_req}, 4'h0);
        ie = 1'b0;
        rd(12'hF13, 4'h0, "t8_ser_msk");
        rd(12'hF03, 4'h0, "t8_ser_fac");
`endif

        // Reset drops an in-flight request and ignores set pulses
        prog_set = 1'b1; cyc(); prog_set = 1'b0;
        ie = 1'b1; cyc();
        chk("t9_req", {3'b0, int_req}, 4'h1);
        reset = 1'b1; prog_set = 1'b1; cyc();
        reset = 1'b0; prog_set = 1'b0;
        chk("t9_rst_req", {3'b0, int_req}, 4'h0);
        chk("t9_rst_vec", int_vector, 4'h0);
        cyc();
        chk("t9_no_rereq", {3'b0, int_req}, 4'h0);
        rd(12'hF02, 4'h0, "t9_prog_fac");
        rd(12'hF12, 4'h0, "t9_prog_msk");
        rd(12'hF10, 4'h0, "t9_clk_msk");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_factor_ctrl.md
INT_FACTOR_CTRL -- requirements
Module: int_factor_ctrl

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port `clock_set`, input, 4 bits: one-cycle set pulses from the clock timer (bit0 32Hz, bit1 8Hz, bit2 2Hz, bit3 1Hz).
REQ-004 SHALL have the port `stopwatch_set`, input, 2 bits: stopwatch set pulses (bit0 10Hz, bit1 1Hz).
REQ-005 SHALL have the ports `prog_set`, `serial_set`, `k0_set`, `k1_set`, input, 1 bit each: source set pulses.
REQ-006 SHALL have the port `bus_addr`, input, 12 bits: CPU data-memory address.
REQ-007 SHALL have the ports `bus_wr` and `bus_rd`, input, 1 bit each: write and read strobes, one cycle each.
REQ-008 SHALL have the port `bus_wdata`, input, 4 bits: write data.
REQ-009 SHALL have the port `bus_rdata`, output, 4 bits: read data, combinational, valid in the `bus_rd` cycle.
REQ-010 SHALL have the port `bus_hit`, output, 1 bit: high when `bus_addr` maps to this block.
REQ-011 SHALL have the port `ie`, input, 1 bit: core interrupt-enable flag.
REQ-012 SHALL have the port `int_req`, output, 1 bit: registered interrupt request.
REQ-013 SHALL have the port `int_vector`, output, 4 bits: low nibble of the vector address, valid while `int_req` is high.
REQ-014 SHALL have the port `int_ack`, input, 1 bit: one-cycle pulse from the core when it begins servicing.

Function
REQ-015 Factor registers SHALL be mapped as: 0xF00 clock[3:0], 0xF01 stopwatch[1:0], 0xF02 prog[0], 0xF03 serial[0], 0xF04 K0[0], 0xF05 K1[0]; unused bits SHALL read 0.
REQ-016 Mask registers SHALL be mapped at 0xF10–0xF15 with the same widths, and SHALL be read/write.
REQ-017 A set pulse SHALL set its factor bit at the next edge; the bit SHALL stay set until cleared.
REQ-018 A `bus_rd` at a factor address SHALL return the current value and clear that whole register at the next edge.
REQ-019 On a set pulse in the same cycle as a read-clear, the set SHALL win: the bit ends at 1, and the read data shows the pre-edge value.
REQ-020 Writes to factor addresses SHALL be ignored; reads of mask addresses SHALL have no side effect.
REQ-021 A source SHALL be pending when (factor & mask) of that source is nonzero.
REQ-022 Priority, highest first, SHALL be: prog 0xC, serial 0xA, K1 0x8, K0 0x6, stopwatch 0x4, clock 0x2.
REQ-023 The state machine SHALL have states IDLE, REQ and WAIT.
REQ-024 IDLE→REQ SHALL occur when `ie` is high and any source is pending; `int_req` SHALL assert one cycle after the qualifying condition, with `int_vector` registered at the same edge.
REQ-025 REQ→WAIT SHALL occur on `int_ack`; `int_req` SHALL drop at that edge.
REQ-026 REQ→IDLE SHALL occur if `ie` falls or nothing is pending, before `int_ack` arrives.
REQ-027 In REQ, `int_vector` SHALL re-register to the current highest-priority pending source each cycle.
REQ-028 WAIT→IDLE SHALL occur once `ie` is low (the core clears IE while servicing).
REQ-029 A pending source whose factor is still uncleared when `ie` rises again SHALL re-request.
REQ-030 `bus_hit` SHALL be high for addresses 0xF00–0xF05 and 0xF10–0xF15 only.

Reset
REQ-031 While `reset` is high at an edge, all factors and masks SHALL become 0, the state SHALL be IDLE, `int_req` SHALL be 0 and `int_vector` SHALL be 0.
REQ-032 Set pulses SHALL be ignored during reset cycles; a request in flight SHALL be dropped with no ack required.

Configuration
REQ-033 Macro `SERIAL_INT_EN`: when defined, the 0xF03/0xF13 registers and the serial priority level SHALL exist.
REQ-034 When `SERIAL_INT_EN` is undefined: `serial_set` SHALL be ignored, 0xF03/0xF13 SHALL read 0 and writes to them SHALL be ignored, `bus_hit` SHALL be low for both addresses, and vector 0xA SHALL never be produced.

Verification
REQ-035 Bench SHALL cover: `clock_set`=0001 pulse, mask 0xF10=0001, `ie`=1 → `int_req`=1 two edges later, `int_vector`=0x2.
REQ-036 Bench SHALL cover: same as REQ-035 but mask=0100 → `int_req` stays 0; then `clock_set`=0100 → `int_req`=1, vector 0x2.
REQ-037 Bench SHALL cover: factor clock=0011, read 0xF00 → `bus_rdata`=0011, next cycle factor=0000, `int_req` falls via REQ→IDLE.
REQ-038 Bench SHALL cover: read 0xF00 while `clock_set`=1000 → `bus_rdata`=old value, factor afterwards=1000.
REQ-039 Bench SHALL cover: prog and clock pending, both masked in → vector 0xC; `int_ack` → `int_req`=0; `ie`=0 then 1 with the prog factor read-cleared → vector 0x2.
REQ-040 Bench SHALL cover: write 0xF13=1 and pulse `serial_set` → with `SERIAL_INT_EN`: vector 0xA; without: read 0xF13=0, no request.
